// File: rtl/bus_scheduler.sv
// Two-bus result scheduler: picks up to two requesting execution combos per cycle
// in round-robin order and drives their addresses onto the common data bus selects.
module bus_scheduler #(
    parameter int          REQUESTERS   = 8,
    parameter logic [7:0]  BASE_ADDRESS = 8'h00,
    parameter logic [7:0]  IDLE_SELECT  = 8'hFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REQUESTERS-1:0] request,
    input  logic                  flush,
    output logic [7:0]            select_0,
    output logic [7:0]            select_1,
    output logic [REQUESTERS-1:0] grant
);

    localparam int PTR_W = $clog2(REQUESTERS);
    localparam int SUM_W = PTR_W + 1;

    logic [PTR_W-1:0]      ptr_r;
    logic [REQUESTERS-1:0] eligible_s;
    logic [REQUESTERS-1:0] grant_next_s;
    logic [PTR_W-1:0]      idx0_s;
    logic [PTR_W-1:0]      idx1_s;
    logic [PTR_W-1:0]      ptr_next_s;
    logic                  hit0_s;
    logic                  hit1_s;

    function automatic logic [PTR_W-1:0] next_index(input logic [PTR_W-1:0] idx);
        logic [PTR_W-1:0] nxt;
        if (idx == PTR_W'(REQUESTERS - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + PTR_W'(1);
        end
        return nxt;
    endfunction

    function automatic logic [7:0] addr_of(input logic [PTR_W-1:0] idx);
        return BASE_ADDRESS + 8'(idx);
    endfunction

    // Circular scan of the eligible set from ptr; the previous grant is masked out
    always_comb begin
        logic [SUM_W-1:0] pos_s;
        logic [PTR_W-1:0] cand_s;
        eligible_s   = request & ~grant;
        hit0_s       = 1'b0;
        hit1_s       = 1'b0;
        idx0_s       = '0;
        idx1_s       = '0;
        grant_next_s = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            pos_s = SUM_W'(ptr_r) + SUM_W'(k);
            if (pos_s >= SUM_W'(REQUESTERS)) begin
                pos_s = pos_s - SUM_W'(REQUESTERS);
            end else begin
                pos_s = pos_s;
            end
            cand_s = pos_s[PTR_W-1:0];
            if (eligible_s[cand_s] && !hit0_s) begin
                hit0_s = 1'b1;
                idx0_s = cand_s;
            end else if (eligible_s[cand_s] && !hit1_s) begin
                hit1_s = 1'b1;
                idx1_s = cand_s;
            end else begin
                hit1_s = hit1_s;
            end
        end
        if (hit0_s) begin
            grant_next_s[idx0_s] = 1'b1;
        end else begin
            grant_next_s = grant_next_s;
        end
        if (hit1_s) begin
            grant_next_s[idx1_s] = 1'b1;
            ptr_next_s           = next_index(idx1_s);
        end else if (hit0_s) begin
            ptr_next_s = next_index(idx0_s);
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Registered selects, grant mirror and round-robin pointer; reset outranks flush
    always_ff @(posedge clock) begin
        if (reset) begin
            select_0 <= IDLE_SELECT;
            select_1 <= IDLE_SELECT;
            grant    <= '0;
            ptr_r    <= '0;
        end else if (flush) begin
            select_0 <= IDLE_SELECT;
            select_1 <= IDLE_SELECT;
            grant    <= '0;
            ptr_r    <= ptr_r;
        end else begin
            select_0 <= hit0_s ? addr_of(idx0_s) : IDLE_SELECT;
            select_1 <= hit1_s ? addr_of(idx1_s) : IDLE_SELECT;
            grant    <= grant_next_s;
            ptr_r    <= ptr_next_s;
        end
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// Scoreboard bench for bus_scheduler: a queue-based reference model predicts each
// cycle's selects and grant; a negedge monitor pops and compares.
module tb_bus_scheduler;

    localparam int         N    = 8;
    localparam logic [7:0] BASE = 8'h00;
    localparam logic [7:0] IDLE = 8'hFF;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush;
    logic [N-1:0] request;
    logic [7:0]   select_0;
    logic [7:0]   select_1;
    logic [N-1:0] grant;

    typedef struct packed {
        logic [7:0]   s0;
        logic [7:0]   s1;
        logic [N-1:0] g;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           total = 0;
    int           bad   = 0;
    int           m_ptr = 0;
    logic [N-1:0] m_prev = '0;

    bus_scheduler #(
        .REQUESTERS  (N),
        .BASE_ADDRESS(BASE),
        .IDLE_SELECT (IDLE)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .flush   (flush),
        .select_0(select_0),
        .select_1(select_1),
        .grant   (grant)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: collect eligible requesters in circular order from the pointer, take two
    task automatic model_step(input logic [N-1:0] req, input logic fl, input logic rs);
        exp_t e;
        int   hits[$];
        e.s0 = IDLE;
        e.s1 = IDLE;
        e.g  = '0;
        if (rs) begin
            m_ptr  = 0;
            m_prev = '0;
        end else if (fl) begin
            m_prev = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (req[i] && !m_prev[i] && hits.size() < 2) hits.push_back(i);
            end
            if (hits.size() > 0) begin
                e.s0         = BASE + 8'(hits[0]);
                e.g[hits[0]] = 1'b1;
            end
            if (hits.size() > 1) begin
                e.s1         = BASE + 8'(hits[1]);
                e.g[hits[1]] = 1'b1;
            end
            if (hits.size() > 0) m_ptr = (hits[hits.size()-1] + 1) % N;
            m_prev = e.g;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] req, input logic fl, input logic rs);
        @(negedge clock);
        #1;
        request = req;
        flush   = fl;
        reset   = rs;
        model_step(req, fl, rs);
    endtask

    task automatic hold(input logic [N-1:0] req, input logic fl, input logic rs, input int n);
        for (int c = 0; c < n; c++) drive(req, fl, rs);
    endtask

    // Monitor: compare outputs against the oldest prediction and check invariants
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("select_0", 32'(select_0), 32'(mon_e.s0));
            check("select_1", 32'(select_1), 32'(mon_e.s1));
            check("grant", 32'(grant), 32'(mon_e.g));
            check("distinct_selects",
                  32'((select_0 != select_1) || (select_0 == IDLE && select_1 == IDLE)), 32'(1));
            check("grant_popcount_le2", 32'($countones(grant) <= 2), 32'(1));
        end
    end

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        request = '0;
        hold(8'h00, 1'b0, 1'b1, 2);
        // single requester: granted, blocked one cycle, granted again
        hold(8'h01, 1'b0, 1'b0, 3);
        hold(8'h00, 1'b0, 1'b0, 1);
        // all requesting from ptr=0: pairs rotate 03,0C,30,C0,03
        hold(8'h00, 1'b0, 1'b1, 1);
        hold(8'hFF, 1'b0, 1'b0, 5);
        // drive ptr to 7, then wrap case 7 and 0
        hold(8'h00, 1'b0, 1'b1, 1);
        hold(8'h40, 1'b0, 1'b0, 1);
        hold(8'h81, 1'b0, 1'b0, 1);
        hold(8'hFF, 1'b0, 1'b0, 2);
        // flush for two cycles, then arbitration resumes from requester 0/1
        hold(8'h00, 1'b0, 1'b1, 1);
        hold(8'h0F, 1'b1, 1'b0, 2);
        hold(8'h0F, 1'b0, 1'b0, 2);
        // reset pulse mid-stream
        hold(8'hFF, 1'b0, 1'b0, 3);
        hold(8'hFF, 1'b0, 1'b1, 1);
        hold(8'hFF, 1'b0, 1'b0, 3);
        // flush together with reset: reset wins
        hold(8'hFF, 1'b1, 1'b1, 1);
        hold(8'hFF, 1'b0, 1'b0, 2);
        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end
        hold(8'h00, 1'b0, 1'b0, 1);
        repeat (3) @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d expected 0 pending", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
